// File: rtl/track_player.sv
// rtl/track_player.sv - 8-step note track playback engine
// Reads one note code per step, holds it TICKS_PER_STEP cycles and drives a square-wave tone.
module track_player #(
  parameter int unsigned TICKS_PER_STEP = 500000,
  parameter int unsigned CLK_HZ         = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       rd_en,
  output logic [2:0] rd_addr,
  input  logic [3:0] rd_data,
  output logic [3:0] note,
  output logic       note_valid,
  output logic [2:0] step,
  output logic       busy,
  output logic       done,
  output logic       piezo
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [3:0]  NOTE_NONE = 4'hF;
  localparam logic [31:0] HOLD_LOAD = 32'(TICKS_PER_STEP - 1);

  // Only ever called with constant arguments, so each table entry folds to a constant.
  function automatic logic [31:0] half_of(input int unsigned freq);
    int unsigned h;
    h = CLK_HZ / (2 * freq);
    if (h == 0) h = 1;
    return 32'(h);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [3:0]  note_q, note_d;
  logic        piezo_q, piezo_d;
  logic [31:0] tone_cnt_q, tone_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] half;
  logic        code_ok;

  assign code_ok = (note_q < 4'd10);

  always_comb begin
    half = 32'd1;
    case (note_q)
      4'd0:    half = half_of(262);
      4'd1:    half = half_of(294);
      4'd2:    half = half_of(330);
      4'd3:    half = half_of(349);
      4'd4:    half = half_of(392);
      4'd5:    half = half_of(440);
      4'd6:    half = half_of(494);
      4'd7:    half = half_of(523);
      4'd8:    half = half_of(587);
      4'd9:    half = half_of(659);
      default: half = 32'd1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    note_d     = note_q;
    piezo_d    = piezo_q;
    tone_cnt_d = tone_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          step_d  = 3'd0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        note_d     = rd_data;
        tone_cnt_d = 32'd0;
        piezo_d    = 1'b0;
        hold_cnt_d = HOLD_LOAD;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt_q == 32'd0) begin
          // Silence the FETCH/WAIT gap between notes.
          piezo_d    = 1'b0;
          tone_cnt_d = 32'd0;
          if (step_q != 3'd7) begin
            step_d  = step_q + 3'd1;
            state_d = S_FETCH;
          end else if (loop) begin
            step_d  = 3'd0;
            state_d = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 32'd1;
          if (!code_ok) begin
            piezo_d = 1'b0;
          end else if (tone_cnt_q == half - 32'd1) begin
            piezo_d    = ~piezo_q;
            tone_cnt_d = 32'd0;
          end else begin
            tone_cnt_d = tone_cnt_q + 32'd1;
          end
        end
      end
      S_FIN: begin
        note_d  = NOTE_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Stop overrides everything, including a simultaneous start.
    if (stop) begin
      state_d    = S_IDLE;
      note_d     = NOTE_NONE;
      piezo_d    = 1'b0;
      tone_cnt_d = 32'd0;
      hold_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      note_q     <= NOTE_NONE;
      piezo_q    <= 1'b0;
      tone_cnt_q <= 32'd0;
      hold_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      note_q     <= note_d;
      piezo_q    <= piezo_d;
      tone_cnt_q <= tone_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign rd_en      = (state_q == S_FETCH);
  assign rd_addr    = step_q;
  assign note       = note_q;
  assign note_valid = (state_q == S_HOLD) && code_ok;
  assign step       = step_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign piezo      = piezo_q;

endmodule

// File: tb/tb_track_player.sv
// tb/tb_track_player.sv - randomized self-checking bench for track_player
// Expected outputs come from an arithmetic model of cycle position within each step.
module tb_track_player;

  localparam int T        = 40;
  localparam int HZ       = 5240;
  localparam int P        = T + 2;
  localparam int PASS_LEN = 8 * P;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [3:0] rd_data = 4'd0;
  logic [3:0] note;
  logic       note_valid;
  logic [2:0] step;
  logic       busy;
  logic       done;
  logic       piezo;

  int checks = 0;
  int errors = 0;
  logic [3:0] mem [8];
  int freq_tab [10] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659};

  always #5 CLK = ~CLK;

  track_player #(.TICKS_PER_STEP(T), .CLK_HZ(HZ)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .loop(loop),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .note(note), .note_valid(note_valid), .step(step),
    .busy(busy), .done(done), .piezo(piezo)
  );

  // One-cycle-latency track memory; outside a read the data bus carries junk.
  always @(posedge CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= 4'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int half_exp(input int code);
    int h;
    h = HZ / (2 * freq_tab[code]);
    return (h < 1) ? 1 : h;
  endfunction

  function automatic logic piezo_exp(input int code, input int j);
    if (code > 9) return 1'b0;
    return ((j / half_exp(code)) % 2) == 1;
  endfunction

  task automatic check_idle_values(input string pfx);
    check_eq({pfx, "_rd_en"}, rd_en, 0);
    check_eq({pfx, "_rd_addr"}, rd_addr, 0);
    check_eq({pfx, "_note"}, note, 4'hF);
    check_eq({pfx, "_note_valid"}, note_valid, 0);
    check_eq({pfx, "_step"}, step, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_piezo"}, piezo, 0);
  endtask

  task automatic play_check(input int passes);
    int last;
    int s;
    int ph;
    int code;
    last = passes * PASS_LEN;
    loop = (passes > 1);
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int c = 1; c <= last + 2; c++) begin
      if (c > 1) @(negedge CLK);
      if (c <= last) begin
        s  = ((c - 1) / P) % 8;
        ph = (c - 1) % P;
        check_eq("busy", busy, 1);
        check_eq("done_early", done, 0);
        check_eq("step", step, s);
        check_eq("rd_en", rd_en, ph == 0);
        if (ph == 0) check_eq("rd_addr", rd_addr, s);
        if (ph >= 2) begin
          code = mem[s];
          check_eq("note", note, code);
          check_eq("note_valid", note_valid, code < 10);
          check_eq("piezo_tone", piezo, piezo_exp(code, ph - 2));
        end else begin
          check_eq("note_valid_gap", note_valid, 0);
          check_eq("piezo_gap", piezo, 0);
        end
      end else if (c == last + 1) begin
        check_eq("done_pulse", done, 1);
        check_eq("busy_fin", busy, 1);
        check_eq("piezo_fin", piezo, 0);
      end else begin
        check_eq("done_after", done, 0);
        check_eq("busy_after", busy, 0);
        check_eq("note_after", note, 4'hF);
        check_eq("note_valid_after", note_valid, 0);
      end
      loop = ((c - 1) / PASS_LEN) < (passes - 1);
    end
    loop = 1'b0;
  endtask

  task automatic advance_to(input int target);
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int c = 1; c < target; c++) @(negedge CLK);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 8; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_idle_values("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Single pass with codes 0 and 5 (half periods 10 and 5) and a rest at step 3.
    randomize_mem();
    mem[0] = 4'd0;
    mem[1] = 4'd5;
    mem[3] = 4'hC;
    play_check(1);

    // Loop through once, drop loop during the second pass.
    randomize_mem();
    play_check(2);

    // Stop during the HOLD of step 2.
    randomize_mem();
    advance_to(2 * P + 3 + $urandom_range(0, T - 1));
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check_eq("stop_busy", busy, 0);
    check_eq("stop_note", note, 4'hF);
    check_eq("stop_piezo", piezo, 0);
    check_eq("stop_done", done, 0);
    check_eq("stop_rd_en", rd_en, 0);
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge CLK);
      check_eq("stop_no_done", done, 0);
      check_eq("stop_stays_idle", busy, 0);
    end
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_eq("start_stop_idle", busy, 0);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Asynchronous reset in the HOLD of step 4, between clock edges.
    randomize_mem();
    mem[4] = 4'd5;
    advance_to(4 * P + 3 + $urandom_range(1, T - 2));
    #2 RST = 1'b0;
    #1 check_idle_values("async_rst");
    @(negedge CLK) RST = 1'b1;
    randomize_mem();
    play_check(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/track_player.md
# track_player

Playback engine for the electronic piano's 8-step note tracks. It is the reading end of the step memory: the keyboard encoder and recorder write 4-bit note codes into the track registers, and this block reads them back in order. For each step it fetches the code through a one-cycle-latency read port, holds it for a programmed step duration, and drives a square-wave tone for the piezo mixer plus a note code for the colour and segment logic.

## Interface
- `TICKS_PER_STEP`, default 500000: clock cycles each step is held; must be ≥ 1.
- `CLK_HZ`, default 1000000: clock frequency, used to build the tone half-period table.
- `CLK`, input, 1: system clock, rising edge.
- `RST`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: level sampled each edge; starts playback from step 0 when idle.
- `stop`, input, 1: aborts playback.
- `loop`, input, 1: sampled at the end of step 7; 1 wraps to step 0.
- `rd_en`, output, 1: read strobe to the track memory.
- `rd_addr`, output, 3: step address being read.
- `rd_data`, input, 4: note code, valid the cycle after `rd_en`.
- `note`, output, 4: code currently sounding; 4'hF when idle.
- `note_valid`, output, 1: 1 in HOLD with a code of 0–9.
- `step`, output, 3: current step index.
- `busy`, output, 1: 1 in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when playback finishes without looping.
- `piezo`, output, 1: square-wave tone.

## Operation
- Codes 0–9 select notes C4, D4, E4, F4, G4, A4, B4, C5, D5, E5 (262, 294, 330, 349, 392, 440, 494, 523, 587, 659 Hz).
- Codes 10–15 are rests: `piezo` stays 0 and `note_valid` stays 0.
- Half period = CLK_HZ / (2·freq), truncated, with a minimum of 1. The table is fixed at elaboration.
- FSM states: IDLE, FETCH, WAIT, HOLD, FIN.
  - IDLE → FETCH on `start`=1 and `stop`=0; `step` is set to 0.
  - FETCH: `rd_en`=1 and `rd_addr`=`step`; go to WAIT.
  - WAIT: `rd_data` is latched into `note`; the tone counter is cleared and `piezo` forced to 0; the hold counter is loaded; go to HOLD.
  - HOLD: lasts exactly TICKS_PER_STEP cycles.
    - At the end with `step`<7: increment `step`, go to FETCH.
    - At the end with `step`=7 and `loop`=1: `step` returns to 0, go to FETCH.
    - At the end with `step`=7 and `loop`=0: go to FIN.
  - FIN: `done`=1 for this single cycle; `note` is set to 4'hF; go to IDLE.
- Tone: in HOLD with a valid code, `piezo` toggles every half-period cycles. In every other state `piezo`=0.
- `stop`=1 in any state: the next state is IDLE, `note` is set to 4'hF, `piezo` goes to 0, and no `done` pulse is produced.
- `stop` and `start` both high: `stop` wins.
- `start` is ignored while `busy`. Holding `start` high keeps restarting from IDLE, one cycle after each FIN.
- `rd_data` is only sampled in WAIT; its value in other states is don't-care.

## Timing
- Reset values: state IDLE, `note`=4'hF, `step`=0, `rd_en`=0, `rd_addr`=0, `note_valid`=0, `busy`=0, `done`=0, `piezo`=0, all counters 0.
- Reset asserted mid-playback returns the block to these values immediately, without waiting for a clock edge.
- Taking edge 0 as the edge where `start` is sampled:
  - `rd_en` is high during cycle 1.
  - `note` and `note_valid` update after edge 2.
  - HOLD spans cycles 3 to 3+TICKS_PER_STEP−1.
- Step period is TICKS_PER_STEP+2 cycles, and the FETCH/WAIT gap between notes is silent.
- `done` is asserted exactly 8·(TICKS_PER_STEP+2)+1 cycles after the `start` edge.
- `busy` falls in the cycle after `done`.
- First `piezo` rise comes half-period cycles after HOLD entry.

## Test plan
- **Full pass, no loop.** Set TICKS_PER_STEP=4, CLK_HZ=5240, memory = 0,1,…,7, `loop`=0, pulse `start`.
  - `rd_addr` sequence is 0..7, one read every 6 cycles.
  - `note` steps through 0..7.
  - `done` pulses once, 49 cycles after `start`.
  - `busy` drops on the next cycle.
- **Tone period.** Set TICKS_PER_STEP=40, CLK_HZ=5240, code 0.
  - `piezo` toggles every 10 cycles, first rise 10 cycles after HOLD entry.
  - With code 5, it toggles every 5 cycles.
- **Rest code.** Memory step 3 holds 4'hC.
  - `piezo`=0 and `note_valid`=0 throughout that HOLD.
  - `note` reads 4'hC during that step.
- **Loop wrap.** Hold `loop`=1.
  - After step 7, `rd_addr` returns to 0 with no `done` pulse.
  - Drop `loop` during the second pass; `done` appears at the end of that pass.
- **Stop.** Assert `stop` in the HOLD of step 2.
  - Next cycle: state is IDLE, `note`=4'hF, `piezo`=0, `busy`=0, `done` never pulses.
  - `start` and `stop` asserted together from IDLE keep the block in IDLE.
- **Async reset.** Assert `RST` low between edges during HOLD.
  - All outputs take their reset values immediately, without a clock edge.
  - After release, a `start` replays from step 0.
